// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic datapath blocks.
package stoch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } stoch_dec_state_t;

  // Result width of the decoder: one extra bit for the full-window count, one for sign.
  function automatic int stoch_dec_width(input int window_log2);
    return window_log2 + 2;
  endfunction

endpackage

// File: rtl/stoch_window_ctr.sv
// Enable-gated sample counter with synchronous clear.
// The terminal-count pulse marks the enabled edge that takes the 2^WINDOW_LOG2-th sample.
module stoch_window_ctr #(
  parameter int WINDOW_LOG2 = 8
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [WINDOW_LOG2:0] LAST = {1'b0, {WINDOW_LOG2{1'b1}}};
  localparam logic [WINDOW_LOG2:0] ONE  = {{WINDOW_LOG2{1'b0}}, 1'b1};

  logic [WINDOW_LOG2:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + ONE;
    end
  end

  assign tc = en && !clr && (count_q == LAST);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stoch_decode.sv
// Stochastic-to-binary decoder: counts ones over a 2^WINDOW_LOG2-sample window
// and holds the (unipolar or bipolar) estimate on a valid/ready output.
module stoch_decode
  import stoch_pkg::*;
#(
  parameter int WINDOW_LOG2 = 8,
  parameter int BIPOLAR     = 0
) (
  input  logic                                    CLK,
  input  logic                                    nRST,
  input  logic                                    start,
  input  logic                                    en,
  input  logic                                    a,
  output logic [stoch_dec_width(WINDOW_LOG2)-1:0] y,
  output logic                                    y_valid,
  input  logic                                    y_ready,
  output logic                                    busy
);

  localparam int YW = stoch_dec_width(WINDOW_LOG2);
  localparam logic [YW-1:0] FULL_Y = {2'b01, {WINDOW_LOG2{1'b0}}};

  stoch_dec_state_t state_q, state_d;
  logic [WINDOW_LOG2:0] ones_q, ones_d, ones_next;
  logic [YW-1:0]        y_q, y_d;
  logic                 y_valid_q, y_valid_d;
  logic                 busy_q, busy_d;
  logic                 ctr_clr, ctr_en, ctr_tc;
  logic                 handshake;

  // Bipolar wraps modulo 2^YW, so 2*ones - 2^W is exact across the whole range.
  function automatic logic [YW-1:0] map_result(input logic [WINDOW_LOG2:0] ones);
    logic signed [YW-1:0] bip;
    bip = $signed({ones, 1'b0}) - $signed(FULL_Y);
    if (BIPOLAR != 0) begin
      return bip;
    end
    return {1'b0, ones};
  endfunction

  assign ctr_clr   = (state_q != ACCUM);
  assign ctr_en    = (state_q == ACCUM) && en;
  assign handshake = y_valid_q && y_ready;
  assign ones_next = ones_q + {{WINDOW_LOG2{1'b0}}, a};

  stoch_window_ctr #(
    .WINDOW_LOG2(WINDOW_LOG2)
  ) u_samples (
    .CLK (CLK),
    .nRST(nRST),
    .clr (ctr_clr),
    .en  (ctr_en),
    .tc  (ctr_tc)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= IDLE;
      ones_q    <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (ctr_tc) state_d = HOLD;
      HOLD:    if (handshake) state_d = start ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters sit at zero outside ACCUM, so any entry into ACCUM starts a fresh window.
  always_comb begin
    ones_d    = '0;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    case (state_q)
      ACCUM: begin
        ones_d = ctr_en ? ones_next : ones_q;
        if (ctr_tc) begin
          y_d       = map_result(ones_next);
          y_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (handshake) y_valid_d = 1'b0;
      end
      default: ;
    endcase
    busy_d = (state_d == ACCUM);
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_stoch_decode.sv
// Scoreboarded bench for stoch_decode at WINDOW_LOG2=4, unipolar and bipolar instances in parallel.
module tb_stoch_decode;

  logic       CLK = 1'b0;
  logic       nRST, start, en, a, y_ready;
  logic [5:0] y_u, y_b;
  logic       yv_u, yv_b, busy_u, busy_b;

  int n_checks = 0;
  int n_errors = 0;
  int q_u[$];
  int q_b[$];

  always #5 CLK = ~CLK;

  stoch_decode #(.WINDOW_LOG2(4), .BIPOLAR(0)) dut_u (
    .CLK(CLK), .nRST(nRST), .start(start), .en(en), .a(a),
    .y(y_u), .y_valid(yv_u), .y_ready(y_ready), .busy(busy_u)
  );

  stoch_decode #(.WINDOW_LOG2(4), .BIPOLAR(1)) dut_b (
    .CLK(CLK), .nRST(nRST), .start(start), .en(en), .a(a),
    .y(y_b), .y_valid(yv_b), .y_ready(y_ready), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // mode 0: a=1, 1: a=0, 2: a alternates 1,0 per taken sample
  task automatic run_window(input int mode, input bit gap, input bit pulse,
                            input bit from_hold, input int exp_edges, input string tag);
    int k, taken, ones;
    bit early;
    @(negedge CLK);
    start = 1'b1; y_ready = from_hold; en = 1'b0; a = 1'b0;
    @(negedge CLK);
    start = 1'b0; y_ready = 1'b0;
    check({tag, "_busy"}, {31'd0, busy_u}, 32'd1);
    check({tag, "_vlow"}, {31'd0, yv_u}, 32'd0);
    k = 0; taken = 0; ones = 0; early = 1'b0;
    while (taken < 16 && k < 100) begin
      k++;
      en = gap ? ~k[0] : 1'b1;
      case (mode)
        0:       a = 1'b1;
        1:       a = 1'b0;
        default: a = (taken % 2 == 0);
      endcase
      start = pulse && (k == 5);
      if (en) begin
        ones += int'(a);
        taken++;
        if (taken == 16) begin
          q_u.push_back(ones);
          q_b.push_back((2 * ones - 16) & 63);
        end
      end
      @(negedge CLK);
      if (taken < 16 && (yv_u || yv_b)) early = 1'b1;
    end
    en = 1'b0; start = 1'b0;
    check({tag, "_lat"}, k, exp_edges);
    check({tag, "_early"}, {31'd0, early}, 32'd0);
    check({tag, "_vu"}, {31'd0, yv_u}, 32'd1);
    check({tag, "_vb"}, {31'd0, yv_b}, 32'd1);
    if (q_u.size() > 0) check({tag, "_yu"}, {26'd0, y_u}, q_u.pop_front());
    if (q_b.size() > 0) check({tag, "_yb"}, {26'd0, y_b}, q_b.pop_front());
  endtask

  task automatic accept(input string tag);
    @(negedge CLK);
    y_ready = 1'b1;
    @(negedge CLK);
    y_ready = 1'b0;
    check({tag, "_acc_v"}, {31'd0, yv_u}, 32'd0);
    check({tag, "_acc_busy"}, {31'd0, busy_u}, 32'd0);
    repeat (3) @(negedge CLK);
    check({tag, "_idle"}, {30'd0, busy_u, yv_b}, 32'd0);
  endtask

  initial begin
    logic [5:0] snap_u, snap_b;
    bit stable;
    nRST = 1'b0; start = 1'b0; en = 1'b0; a = 1'b0; y_ready = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_y", {20'd0, y_u, y_b}, 32'd0);
    check("rst_v", {30'd0, yv_u, yv_b}, 32'd0);
    check("rst_busy", {30'd0, busy_u, busy_b}, 32'd0);
    nRST = 1'b1;

    run_window(0, 1'b0, 1'b0, 1'b0, 16, "ones");
    accept("ones");
    run_window(1, 1'b0, 1'b0, 1'b0, 16, "zeros");
    accept("zeros");
    run_window(2, 1'b0, 1'b0, 1'b0, 16, "alt");
    accept("alt");
    run_window(0, 1'b1, 1'b0, 1'b0, 32, "gaps");
    accept("gaps");
    run_window(2, 1'b0, 1'b1, 1'b0, 16, "pulse");

    // Backpressure: result frozen while the stream and start wiggle.
    snap_u = y_u; snap_b = y_b; stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 1'($urandom_range(0, 1));
      en = 1'b1;
      start = (i == 10);
      @(negedge CLK);
      if (y_u !== snap_u || y_b !== snap_b || yv_u !== 1'b1 || yv_b !== 1'b1 || busy_u !== 1'b0)
        stable = 1'b0;
    end
    en = 1'b0; start = 1'b0;
    check("bp_stable", {31'd0, stable}, 32'd1);
    check("bp_y", {26'd0, y_u}, 32'd8);
    accept("bp");

    // Reset partway through a window of all ones.
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0; en = 1'b1; a = 1'b1;
    repeat (6) @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1; en = 1'b0;
    check("mrst_y", {26'd0, y_u}, 32'd0);
    check("mrst_v", {30'd0, yv_u, yv_b}, 32'd0);
    check("mrst_busy", {31'd0, busy_u}, 32'd0);
    repeat (2) @(negedge CLK);
    check("mrst_idle", {31'd0, busy_u}, 32'd0);
    run_window(2, 1'b0, 1'b0, 1'b0, 16, "fresh");

    // Handshake with start in HOLD restarts immediately: 16 + 1 cycles per result.
    run_window(0, 1'b0, 1'b0, 1'b1, 16, "b2b1");
    run_window(1, 1'b0, 1'b0, 1'b1, 16, "b2b2");
    accept("b2b");

    check("sb_empty", q_u.size() + q_b.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stoch_decode.md
# stoch_decode

Stochastic-to-binary decoder: counts the ones in a fixed window of 2^WINDOW_LOG2 sampled bits of a stochastic bitstream and presents the estimate as a fixed-point count on a valid/ready output. It is the reading end of the stochastic datapath. It converts the outputs of stochastic arithmetic blocks (divider, multiplier, adder) back to binary for host readout or for binary-domain logic.

## Interface
- WINDOW_LOG2, default 8: log2 of samples per window; legal range 2..16.
- BIPOLAR, default 0: 0 = unipolar result (ones count); 1 = bipolar result (2·ones − 2^WINDOW_LOG2).
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- start  in  1  request a new window; sampled in IDLE (and in HOLD, see Operation).
- en  in  1  sample qualifier; the bit on `a` is counted only while en=1.
- a  in  1  stochastic input bit.
- y  out  WINDOW_LOG2+2  result; signed two's complement when BIPOLAR=1, zero-extended otherwise.
- y_valid  out  1  result valid; held until accepted.
- y_ready  in  1  consumer accepts y when y_valid && y_ready at a rising edge.
- busy  out  1  high in ACCUM.

## Operation
- States: IDLE, ACCUM, HOLD.
- IDLE: ones=0, samples=0. start=1 → ACCUM.
- ACCUM: on each edge with en=1: ones += a, samples += 1. No change when en=0. start is ignored.
- When the 2^WINDOW_LOG2-th sample is taken, y is loaded with the final result on the same edge. y_valid←1 and state→HOLD.
- HOLD:
  - y and y_valid are stable.
  - Stream bits are dropped.
  - On handshake with start=0 → IDLE, y_valid←0.
  - On handshake with start=1 → ACCUM directly, with counters cleared.
  - start without handshake is ignored.
- Arithmetic:
  - ones and samples are WINDOW_LOG2+1 bits unsigned. Neither can overflow, because counting stops at 2^WINDOW_LOG2.
  - Unipolar: y = ones, range 0..2^W.
  - Bipolar: y = (ones<<1) − 2^W, range −2^W..+2^W, computed at full WINDOW_LOG2+2 width.
- y retains its last value outside HOLD; consumers must qualify it with y_valid.

## Timing
- Reset values: state=IDLE, ones=0, samples=0, y=0, y_valid=0, busy=0.
- Reset mid-window or mid-HOLD discards the partial count and any pending result. The cycle after nRST rises starts in IDLE.
- Latency:
  - start high at edge t0 → ACCUM from t0.
  - With en held high, samples are taken at edges t0+1 … t0+2^W.
  - y_valid is high after edge t0+2^W.
  - With en gaps, completion is delayed by one cycle per en=0 cycle in ACCUM.
- Back-to-back throughput: holding start=1 and y_ready=1 gives one result per 2^W+1 cycles. The acceptance edge is not a sample edge.
- busy is registered and equals (state==ACCUM).

## Structure
- Add to the shared stochastic package (stoch_pkg):
  - typedef enum logic [1:0] stoch_dec_state_t {IDLE, ACCUM, HOLD}.
  - Function stoch_dec_width(window_log2) returning window_log2+2.
- One sub-module, stoch_window_ctr. It is an enable-gated up-counter with synchronous clear and a terminal-count pulse at 2^WINDOW_LOG2. It is used for the samples count.
- The ones accumulator, the bipolar mapping and the FSM live in stoch_decode.

## Test plan
- W=4, unipolar, a=1, en=1, start pulse at t0 → y_valid high after edge t0+16, y=16; a=0 → y=0.
- W=4, unipolar, a=1010… → y=8. Same stream with BIPOLAR=1 → y=0. a=0 with BIPOLAR=1 → y=−16 (6'b110000).
- W=4, en toggling 1/0 each cycle, a=1 → y=16, y_valid after edge t0+32.
- Backpressure: y_ready=0 for 20 cycles after valid → y and y_valid stable, a toggling has no effect. y_ready=1 → y_valid low next cycle, state IDLE.
- nRST low for one cycle at sample 7 of 16 → y=0, y_valid=0, IDLE. A new start yields the correct count from a fresh window only.
- start=1 and y_ready=1 in the same HOLD cycle, a=1 → next y_valid after exactly 16 more edges, y=16. start pulsed during ACCUM → no restart, result unchanged.
